rf_fifo_ctl: RTL
================

Name: rf_fifo_ctl

Overview:
Flow-control sequencer that turns an external 1-read/1-write register file (combinational read, registered write) into a synchronous valid/ready FIFO. It owns the read and write pointers, the occupancy counter and the full/empty logic, and drives the register-file address, data and write-enable ports. It sits between a producer and a consumer stage in the flow_ctl datapath. The storage array is instantiated beside it, not inside it.

Parameters:
ADDRW, 4, register-file address width; FIFO depth DEPTH = 2**ADDRW entries
DATAW, 8, payload width
AFULL_LVL, 2**ADDRW - 2, occupancy at or above which o_almost_full asserts; legal range 1..DEPTH

Ports:
clk  in  1  single clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
i_flush  in  1  synchronous clear of FIFO contents; pointers and count return to 0
i_enq_valid  in  1  producer has data
o_enq_ready  out  1  FIFO accepts data this cycle
i_enq_data  in  DATAW  producer payload
o_deq_valid  out  1  head entry valid
i_deq_ready  in  1  consumer takes the head entry this cycle
o_deq_data  out  DATAW  head entry payload
o_count  out  ADDRW+1  current occupancy, 0..DEPTH
o_almost_full  out  1  o_count >= AFULL_LVL
o_rf_rd_addr  out  ADDRW  register-file read address (head pointer)
i_rf_rd_data  in  DATAW  register-file read data (combinational from o_rf_rd_addr)
o_rf_wr_addr  out  ADDRW  register-file write address (tail pointer)
o_rf_wr_data  out  DATAW  register-file write data
o_rf_wr_en  out  1  register-file write strobe

Behaviour:
- State: wr_ptr and rd_ptr, each ADDRW+1 bits (MSB is the wrap bit); count is ADDRW+1 bits.
- Empty when wr_ptr == rd_ptr. Full when the low ADDRW bits are equal and the MSBs differ. count must equal wr_ptr - rd_ptr mod 2**(ADDRW+1) at all times.
- o_enq_ready = !full. It depends only on registered state, with no combinational path from i_deq_ready.
- o_deq_valid = !empty. It has no path from i_enq_valid.
- enq = i_enq_valid & o_enq_ready. deq = o_deq_valid & i_deq_ready.
- Register-file drive:
  - o_rf_wr_en = enq.
  - o_rf_wr_addr = wr_ptr[ADDRW-1:0].
  - o_rf_wr_data = i_enq_data.
  - o_rf_rd_addr = rd_ptr[ADDRW-1:0].
  - o_deq_data = i_rf_rd_data, combinational pass-through.
- On enq: wr_ptr increments by 1, wrapping naturally.
- On deq: rd_ptr increments by 1.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither.
- Latency: data enqueued in cycle N is visible on o_deq_data with o_deq_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass when empty.
- Full with i_deq_ready=1: enqueue is still refused that cycle (ready is low). The dequeue proceeds, and ready rises in the next cycle.
- Empty with i_enq_valid=1: only the enqueue happens; o_deq_valid rises in the next cycle.
- Simultaneous enq and deq at occupancy 1..DEPTH-1: both pointers advance and count holds.
- Pointer wrap: addresses go DEPTH-1 -> 0. The MSB toggles on wrap, so full and empty stay distinguishable.
- o_almost_full is combinational from registered count.
- Reset (rst_n=0 at posedge) sets wr_ptr=0, rd_ptr=0, count=0. Outputs after reset:
  - o_enq_ready=1
  - o_deq_valid=0
  - o_count=0
  - o_almost_full=0 (1 only when AFULL_LVL=0, which is illegal)
  - o_rf_wr_en=0 while i_enq_valid=0
- o_rf_wr_en is suppressed (forced to 0) whenever rst_n=0 or i_flush=1, regardless of i_enq_valid.
- Reset or flush mid-operation discards all entries; register-file contents are left stale and are never read.
- i_flush=1 has the same effect as reset on pointers and count. It overrides any enq or deq in the same cycle. Outputs in the flush cycle still reflect pre-flush state, and the consumer must ignore any handshake in that cycle.
- Register-file contents are don't-care after reset. The controller never presents an unwritten address with o_deq_valid=1.

Test Plan:
- Reset and fill (ADDRW=2, DEPTH=4): reset, then enqueue 0x11, 0x22, 0x33, 0x44 back-to-back with i_deq_ready=0.
  - o_count goes 1..4.
  - o_almost_full=1 from count 2.
  - o_enq_ready=0 after the 4th write; a 5th valid (0x55) is not written (o_rf_wr_en=0).
- Drain order: from full, hold i_deq_ready=1 for 4 cycles.
  - o_deq_data reads 0x11, 0x22, 0x33, 0x44.
  - o_deq_valid=0 and o_count=0 afterwards; o_rf_rd_addr wraps back to 0.
- Streaming wrap: valid=ready=1 continuously for 10 beats, payloads 0..9.
  - After the first beat, count holds at 1.
  - Consumer sees 0..9 in order.
  - Pointers wrap twice with no loss or duplication.
- Full plus dequeue: at count=4, assert i_enq_valid (0xAA) and i_deq_ready together.
  - Dequeue happens and enqueue is refused; count becomes 3.
  - Next cycle 0xAA is accepted.
- Empty plus enqueue: at count=0, assert i_enq_valid (0x5C) and i_deq_ready.
  - o_deq_valid=0 that cycle.
  - Next cycle o_deq_valid=1 with o_deq_data=0x5C.
- Flush and reset mid-stream: at count=3, pulse i_flush with i_enq_valid=1.
  - Next cycle count=0, o_deq_valid=0, and no write was issued in the flush cycle.
  - Repeat with rst_n=0 for the same result.

Source files
------------

// File: rtl/rf_fifo_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : rf_fifo_ctl
//  Purpose  : Valid/ready FIFO sequencer around an external 1R/1W register
//             file (combinational read, registered write). Owns the head and
//             tail pointers, the occupancy counter and full/empty detection.
//  Revision : 1.0  initial release
// ============================================================================
module rf_fifo_ctl #(
  parameter int ADDRW     = 4,
  parameter int DATAW     = 8,
  parameter int AFULL_LVL = 2**ADDRW - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  // producer side
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [DATAW-1:0] i_enq_data,
  // consumer side
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [DATAW-1:0] o_deq_data,
  // status
  output logic [ADDRW:0]   o_count,
  output logic             o_almost_full,
  // register-file drive
  output logic [ADDRW-1:0] o_rf_rd_addr,
  input  logic [DATAW-1:0] i_rf_rd_data,
  output logic [ADDRW-1:0] o_rf_wr_addr,
  output logic [DATAW-1:0] o_rf_wr_data,
  output logic             o_rf_wr_en
);

  localparam logic [ADDRW:0] c_one       = {{ADDRW{1'b0}}, 1'b1};
  localparam logic [ADDRW:0] c_afull_lvl = (ADDRW+1)'(AFULL_LVL);

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [ADDRW:0] r_wr_ptr;
  logic [ADDRW:0] r_rd_ptr;
  logic [ADDRW:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  // Full/empty come only from registered pointers, so ready and valid never
  // see a combinational path from the opposite side's handshake input.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDRW-1:0] == r_rd_ptr[ADDRW-1:0]) &&
                   (r_wr_ptr[ADDRW] != r_rd_ptr[ADDRW]);

  assign o_enq_ready = ~w_full;
  assign o_deq_valid = ~w_empty;

  assign w_enq = i_enq_valid & o_enq_ready;
  assign w_deq = o_deq_valid & i_deq_ready;

  // The write strobe is masked during reset/flush so a discarded beat never
  // lands in the storage array.
  assign o_rf_wr_en   = w_enq & rst_n & ~i_flush;
  assign o_rf_wr_addr = r_wr_ptr[ADDRW-1:0];
  assign o_rf_wr_data = i_enq_data;
  assign o_rf_rd_addr = r_rd_ptr[ADDRW-1:0];
  assign o_deq_data   = i_rf_rd_data;

  assign o_count       = r_count;
  assign o_almost_full = (r_count >= c_afull_lvl);

  // Pointer and occupancy update; flush behaves exactly like reset and wins
  // over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
